// File: rtl/fetch_decode_buffer_pkg.sv
// Shared LC-3b types for the fetch/decode boundary: machine word, register index,
// buffered fetch entry and the all-zero BR NOP presented to decode when empty.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;

    typedef struct packed {
        lc3b_word pc;
        lc3b_word instr;
    } lc3b_fetch_entry;

    localparam lc3b_word FDB_NOP = 16'h0000;

endpackage

// File: rtl/fetch_decode_buffer_storage.sv
// fdb_storage: DEPTH-entry register array of {pc, instr} with one write port,
// one combinational read port and asynchronous clear.
module fdb_storage
    import lc3b_types::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  lc3b_fetch_entry       wdata,
    input  logic [PTR_W-1:0]      raddr,
    output lc3b_fetch_entry       rdata
);

    lc3b_fetch_entry mem [DEPTH];

    // NOTE: the array is small and decode must see zeros after reset, so every
    // entry is cleared; a large RAM would normally be left unreset instead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode FIFO with valid/ready handshake, flush and register-field extraction.
// Optional same-cycle empty bypass is enabled by defining FETCH_DECODE_BYPASS_EN.
module fetch_decode_buffer
    import lc3b_types::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [15:0]       in_pc,
    input  logic [15:0]       in_instr,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic [15:0]       out_pc,
    output logic [15:0]       out_instr,
    output logic [2:0]        out_dest,
    output logic [2:0]        out_src1,
    output logic [2:0]        out_src2,
    input  logic              out_ready,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occupancy;
    logic             stored_valid;
    logic             push;
    logic             pop;
    lc3b_fetch_entry  wr_entry;
    lc3b_fetch_entry  rd_entry;
    lc3b_fetch_entry  head;

    assign wr_entry     = '{pc: in_pc, instr: in_instr};
    assign stored_valid = (occupancy != '0);
    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready     = (occupancy != FULL_COUNT);
    assign pop          = stored_valid & out_ready & ~flush;

`ifdef FETCH_DECODE_BYPASS_EN
    logic bypass;
    assign bypass = ~stored_valid & in_valid & ~flush;
    // A bypassed entry taken by decode in the same cycle is never written.
    assign push   = in_valid & in_ready & ~flush & ~(bypass & out_ready);
`else
    assign push   = in_valid & in_ready & ~flush;
`endif

    fdb_storage #(.DEPTH(DEPTH)) u_storage (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      occupancy <= occupancy + 1'b1;
            else if (pop && !push) occupancy <= occupancy - 1'b1;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        out_valid = stored_valid;
        head      = stored_valid ? rd_entry : '{pc: FDB_NOP, instr: FDB_NOP};
`ifdef FETCH_DECODE_BYPASS_EN
        if (bypass) begin
            out_valid = 1'b1;
            head      = wr_entry;
        end
`endif
    end

    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign out_dest  = head.instr[11:9];
    assign out_src1  = head.instr[8:6];
    assign out_src2  = head.instr[2:0];
    assign count     = occupancy;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed bench for fetch_decode_buffer (DEPTH=2); bypass expectations follow
// FETCH_DECODE_BYPASS_EN when it is defined for the build.
module tb_fetch_decode_buffer;
    import lc3b_types::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_pc;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic [2:0]  out_dest;
    logic [2:0]  out_src1;
    logic [2:0]  out_src2;
    logic        out_ready;
    logic [1:0]  count;

    int vectors = 0;
    int miscompares = 0;

    fetch_decode_buffer #(.DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_dest  (out_dest),
        .out_src1  (out_src1),
        .out_src2  (out_src2),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] instr, input logic rdy);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr;
        out_ready = rdy;
    endtask

    initial begin
        logic [15:0] next_pc;

        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_pc",    out_pc,    0);
        check("rst_out_instr", out_instr, 0);
        check("rst_dest",      out_dest,  0);
        check("rst_count",     count,     0);
        tick();
        reset = 1'b0;
        tick();

        // Single push, fields extracted from 0x1261 are all 1.
        drive(1'b1, 16'h0100, 16'h1261, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t1_out_valid", out_valid, 1);
        check("t1_out_pc",    out_pc,    16'h0100);
        check("t1_dest",      out_dest,  1);
        check("t1_src1",      out_src1,  1);
        check("t1_src2",      out_src2,  1);
        check("t1_count",     count,     1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_pop_count",  count,     0);
        check("t1_pop_valid",  out_valid, 0);
        check("t1_nop_instr",  out_instr, 16'h0000);

        // Fill to full, reject third push, then drain in order.
        drive(1'b1, 16'h0100, 16'hA100, 1'b0);
        tick();
        drive(1'b1, 16'h0102, 16'hA102, 1'b0);
        tick();
        check("full_count",    count,    2);
        check("full_in_ready", in_ready, 0);
        drive(1'b1, 16'h0104, 16'hA104, 1'b0);
        tick();
        check("full_hold_count", count,  2);
        check("full_hold_pc",    out_pc, 16'h0100);
        out_ready = 1'b1;
        #1;
        check("full_ready_low_with_out_ready", in_ready, 0);
        tick();
        check("pop1_count",    count,    1);
        check("pop1_pc",       out_pc,   16'h0102);
        check("pop1_in_ready", in_ready, 1);
        tick();
        check("push_pop_count", count,     1);
        check("push_pop_pc",    out_pc,    16'h0104);
        check("push_pop_instr", out_instr, 16'hA104);
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("drain_count", count, 0);
        check("drain_valid", out_valid, 0);

        // Steady stream: every PC delivered exactly once, in order.
        next_pc = 16'h3000;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'h3000 + 16'(2 * i), 16'h5000 + 16'(i), 1'b1);
            #1;
            if (out_valid) begin
                check("stream_pc", out_pc, next_pc);
                next_pc = next_pc + 16'd2;
            end
            tick();
`ifdef FETCH_DECODE_BYPASS_EN
            check("stream_count", count, 0);
`else
            check("stream_count", count, 1);
`endif
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            if (out_valid) begin
                check("stream_drain_pc", out_pc, next_pc);
                next_pc = next_pc + 16'd2;
            end
            tick();
        end
        out_ready = 1'b0;
        check("stream_total", next_pc, 16'h3014);
        check("stream_empty", count, 0);

        // Flush with concurrent in_valid: everything discarded.
        drive(1'b1, 16'h0500, 16'hB500, 1'b0);
        tick();
        drive(1'b1, 16'h0502, 16'hB502, 1'b0);
        tick();
        check("pre_flush_count", count, 2);
        drive(1'b1, 16'h0200, 16'hB200, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        check("flush_count",     count,     0);
        check("flush_valid",     out_valid, 0);
        check("flush_instr",     out_instr, 16'h0000);
        check("flush_in_ready",  in_ready,  1);
        drive(1'b1, 16'h0600, 16'hB600, 1'b0);
        tick();
        in_valid = 1'b0;
        check("post_flush_pc", out_pc, 16'h0600);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_flush_empty", count, 0);

        // Asynchronous reset between edges.
        drive(1'b1, 16'h0700, 16'hB700, 1'b0);
        tick();
        in_valid = 1'b0;
        check("pre_areset_count", count, 1);
        #2;
        reset = 1'b1;
        #1;
        check("areset_valid", out_valid, 0);
        check("areset_count", count,     0);
        check("areset_pc",    out_pc,    0);
        tick();
        reset = 1'b0;
        tick();

        // Empty with in_valid and out_ready high.
        drive(1'b1, 16'h0400, 16'h1261, 1'b1);
        #1;
`ifdef FETCH_DECODE_BYPASS_EN
        check("bypass_valid", out_valid, 1);
        check("bypass_pc",    out_pc,    16'h0400);
        tick();
        check("bypass_count", count, 0);
`else
        check("no_bypass_valid", out_valid, 0);
        check("no_bypass_pc",    out_pc,    16'h0000);
        tick();
        check("no_bypass_count", count,  1);
        check("no_bypass_head",  out_pc, 16'h0400);
`endif
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
- Small FIFO between the instruction-fetch stage and the decode stage.
- Captures {PC, instruction} pairs when memory returns fetch data, and presents them to decode with a valid/ready handshake.
- Extracts register fields from the head instruction.
- A flush from branch/jump redirect discards every buffered entry, so wrong-path instructions never reach decode.

Parameters:
- DEPTH, 2, number of entries; legal values 2 or 4 (power of two).
- PTR_W, $clog2(DEPTH), read/write pointer width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch has a valid instruction this cycle (memory resp)
- in_pc  input  16  lc3b_word, PC of the fetched instruction
- in_instr  input  16  lc3b_word, fetched instruction
- in_ready  output  1  buffer can accept; fetch stalls when low
- flush  input  1  redirect (taken branch/jump); discard all entries
- out_valid  output  1  head entry valid for decode
- out_pc  output  16  lc3b_word, head PC
- out_instr  output  16  lc3b_word, head instruction
- out_dest  output  3  lc3b_reg, out_instr[11:9]
- out_src1  output  3  lc3b_reg, out_instr[8:6]
- out_src2  output  3  lc3b_reg, out_instr[2:0]
- out_ready  input  1  decode consumes head this cycle
- count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (asynchronous, active-high): wr_ptr=0, rd_ptr=0, count=0, all storage=0. Outputs during and after reset: out_valid=0, in_ready=1, out_pc=0, out_instr=0, register fields=0.
- Handshake signals:
  - in_ready = (count != DEPTH). It is registered-state only and has no combinational path from out_ready.
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
- Push writes entry[wr_ptr] and advances wr_ptr; pop advances rd_ptr. Pointers wrap modulo DEPTH.
- count update: push without pop gives +1; pop without push gives -1; simultaneous push and pop leaves count unchanged.
- Full (count==DEPTH): in_ready=0 even if out_ready=1 in that cycle. A push is accepted the cycle after a pop.
- Empty (count==0): out_valid=0 (non-bypass build). out_instr/out_pc are forced to 16'h0000, so decode sees an all-zero BR NOP.
- Flush has priority over everything in the same cycle. On the next edge: count=0, wr_ptr=rd_ptr=0. The concurrent in_valid is dropped and no pop is counted.
- Latency: 1 cycle from push to out_valid (non-bypass build).
- Order is strictly FIFO. No entry is duplicated or skipped across pointer wrap.
- out_valid must stay high, with out_* stable, until popped or flushed.
- Reset asserted mid-operation clears state immediately, regardless of clk.

Optional Feature:
- Macro: FETCH_DECODE_BYPASS_EN.
- Defined: when count==0 and in_valid & ~flush, the input is presented combinationally in the same cycle: out_valid=1, out_pc=in_pc, out_instr=in_instr.
  - If out_ready is also high, the entry is consumed without being written: count stays 0 and pointers do not move.
  - Otherwise it is pushed normally.
- Undefined: no combinational in-to-out path; minimum latency is 1 cycle.

Decomposition:
- lc3b_types gains:
  - typedef struct packed {lc3b_word pc; lc3b_word instr;} lc3b_fetch_entry;
  - localparam FDB_NOP = 16'h0000.
- Existing lc3b_word and lc3b_reg are used for ports.
- One sub-module: fdb_storage. It is a DEPTH x lc3b_fetch_entry register array with a write port (we, waddr, wdata), a combinational read port (raddr, rdata), and asynchronous reset to zero.
- Pointer, count and handshake logic live in fetch_decode_buffer.

Test Plan:
- Reset, then in_valid=1, in_pc=16'h0100, in_instr=16'h1261, out_ready=0 for one cycle. Next cycle expect: out_valid=1, out_pc=0x0100, out_dest=1, out_src1=1, out_src2=1, count=1.
- Push 0x0100, 0x0102 with out_ready=0. Expect count=2 and in_ready=0. A third push of 0x0104 is not accepted. Then out_ready=1: outputs 0x0100 then 0x0102 in order; in_ready returns 1 the cycle after the first pop.
- Steady stream with in_valid=out_ready=1 for 10 cycles, PCs 0x3000..0x3012. Expect count constant at 1 after fill, every PC delivered once in order, and pointers wrapping without loss.
- With count=2, assert flush together with in_valid (pc 0x0200). Next cycle expect count=0, out_valid=0, out_instr=0x0000; entry 0x0200 is never output.
- Assert reset asynchronously between clock edges while count=1. Expect out_valid=0 and count=0 immediately, before the next edge.
- FETCH_DECODE_BYPASS_EN defined, empty, in_valid=out_ready=1 with pc 0x0400. Expect out_valid=1 and out_pc=0x0400 in the same cycle, and count stays 0.
